// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot multi-cycle phase generator for the core.
// Walks NPHASE phases per instruction, stretches a phase while its stage
// reports busy (bounded by an optional watchdog), parks at instruction
// boundaries for halt / single-step, and counts retired instructions.
module phase_sequencer #(
  parameter int NPHASE       = 5,
  parameter int WAIT_MAX     = 15,
  parameter int CNTW         = 4,
  parameter int XLEN         = 32,
  parameter int START_HALTED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPHASE-1:0] phase_busy,
  input  logic              halt_req,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              clr_timeout,
  output logic [NPHASE-1:0] phase,
  output logic [NPHASE-1:0] stall,
  output logic              retire,
  output logic              halted,
  output logic              timeout,
  output logic [XLEN-1:0]   instret
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0]        ST_RESET = (START_HALTED != 0) ? ST_HALT : ST_RUN;
  localparam bit                WD_EN    = (WAIT_MAX != 0);
  localparam logic [CNTW-1:0]   WAIT_LIM = CNTW'(WAIT_MAX);
  localparam logic [NPHASE-1:0] PH_FIRST = {{(NPHASE-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic [CNTW-1:0]   wait_q, wait_d;
  logic              timeout_q;
  logic [XLEN-1:0]   instret_q;

  logic running;
  logic busy_cur;
  logic force_adv;
  logic adv;

  // Current-phase busy, watchdog force and advance qualification.
  assign running   = (state_q != ST_HALT);
  assign busy_cur  = |(phase_q & phase_busy);
  assign force_adv = WD_EN & running & busy_cur & (wait_q == WAIT_LIM);
  assign adv       = running & (|phase_q) & (~busy_cur | force_adv);

  assign phase   = phase_q;
  assign stall   = phase_q & phase_busy & {NPHASE{~force_adv}};
  assign retire  = adv & phase_q[NPHASE-1];
  assign halted  = (state_q == ST_HALT);
  assign timeout = timeout_q;
  assign instret = instret_q;

  // Next state, phase pointer and wait counter.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    if (state_q == ST_HALT) begin
      wait_d = '0;
      if (run_req && !halt_req) begin
        state_d = ST_RUN;
        phase_d = PH_FIRST;
      end else if (step_req) begin
        state_d = ST_STEP;
        phase_d = PH_FIRST;
      end
    end else if (phase_q == '0) begin
      // First edge out of reset: start fetching.
      phase_d = PH_FIRST;
      wait_d  = '0;
    end else if (adv) begin
      wait_d = '0;
      if (retire && (state_q == ST_STEP || halt_req)) begin
        state_d = ST_HALT;
        phase_d = '0;
      end else begin
        phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
      end
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      phase_q <= '0;
      wait_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
    end
  end

  // Sticky watchdog flag; a new force-advance beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (force_adv) begin
      timeout_q <= 1'b1;
    end else if (clr_timeout) begin
      timeout_q <= 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench. A behavioural model (integer phase
// index, mode enum) predicts every cycle's outputs; predictions are queued
// when stimulus is applied and compared when the outputs are sampled.
// A second instance (NPHASE=2, no watchdog, 8-bit counter, starts halted)
// covers the two-phase wrap, disabled watchdog and counter wrap.
module tb_phase_sequencer;

  localparam int NP = 5;
  localparam int WM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NP-1:0] busy;
  logic          halt_req, run_req, step_req, clr_timeout;
  logic [NP-1:0] phase, stall;
  logic          retire, halted, timeout;
  logic [31:0]   instret;

  logic [1:0] s_busy  = '0;
  logic       s_run   = 1'b0;
  logic       s_halt  = 1'b0;
  logic       s_step  = 1'b0;
  logic       s_clr   = 1'b0;
  logic [1:0] s_phase, s_stall;
  logic       s_retire, s_halted, s_timeout;
  logic [7:0] s_instret;

  phase_sequencer #(
    .NPHASE(NP), .WAIT_MAX(WM), .CNTW(4), .XLEN(32), .START_HALTED(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .phase_busy(busy), .halt_req(halt_req),
    .run_req(run_req), .step_req(step_req), .clr_timeout(clr_timeout),
    .phase(phase), .stall(stall), .retire(retire), .halted(halted),
    .timeout(timeout), .instret(instret)
  );

  phase_sequencer #(
    .NPHASE(2), .WAIT_MAX(0), .CNTW(4), .XLEN(8), .START_HALTED(1)
  ) u_two (
    .clk(clk), .rst_n(rst_n), .phase_busy(s_busy), .halt_req(s_halt),
    .run_req(s_run), .step_req(s_step), .clr_timeout(s_clr),
    .phase(s_phase), .stall(s_stall), .retire(s_retire), .halted(s_halted),
    .timeout(s_timeout), .instret(s_instret)
  );

  typedef struct packed {
    logic [NP-1:0] phase;
    logic [NP-1:0] stall;
    logic          retire;
    logic          halted;
    logic          timeout;
    logic [31:0]   instret;
  } exp_t;

  typedef enum {M_RUN, M_STEP, M_HALT} mode_e;

  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  int          m_idx;
  mode_e       m_mode;
  int          m_wait;
  bit          m_to;
  logic [31:0] m_ret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx  = -1;
    m_mode = M_RUN;
    m_wait = 0;
    m_to   = 1'b0;
    m_ret  = '0;
  endtask

  // Assert reset away from the clock edge, check the asynchronous clear,
  // then release it on the following falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_phase", phase, 0);
    check("rst_instret", instret, 0);
    check("rst_timeout", timeout, 0);
    check("rst_halted", halted, 0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: apply inputs, predict outputs, compare, step the model.
  task automatic tick(input logic [NP-1:0] b, input logic h, input logic r,
                      input logic s, input logic c);
    exp_t e;
    bit   bz, f, a, rt;
    busy = b; halt_req = h; run_req = r; step_req = s; clr_timeout = c;
    e = '0;
    if (m_idx >= 0) e.phase[m_idx] = 1'b1;
    bz = 1'b0; f = 1'b0; a = 1'b0;
    if (m_mode != M_HALT && m_idx >= 0) begin
      bz = b[m_idx];
      f  = (WM != 0) && bz && (m_wait == WM);
      a  = !bz || f;
    end
    if (bz && !f) e.stall[m_idx] = 1'b1;
    rt        = a && (m_idx == NP - 1);
    e.retire  = rt;
    e.halted  = (m_mode == M_HALT);
    e.timeout = m_to;
    e.instret = m_ret;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check("phase", phase, e.phase);
    check("stall", stall, e.stall);
    check("retire", retire, e.retire);
    check("halted", halted, e.halted);
    check("timeout", timeout, e.timeout);
    check("instret", instret, e.instret);
    if (f) m_to = 1'b1;
    else if (c) m_to = 1'b0;
    if (m_mode == M_HALT) begin
      m_wait = 0;
      if (r && !h) begin
        m_mode = M_RUN;  m_idx = 0;
      end else if (s) begin
        m_mode = M_STEP; m_idx = 0;
      end
    end else if (m_idx < 0) begin
      m_idx = 0; m_wait = 0;
    end else if (a) begin
      m_wait = 0;
      if (rt) begin
        m_ret = m_ret + 1;
        if (m_mode == M_STEP || h) begin
          m_mode = M_HALT; m_idx = -1;
        end else begin
          m_idx = 0;
        end
      end else begin
        m_idx = m_idx + 1;
      end
    end else begin
      m_wait = m_wait + 1;
    end
    @(negedge clk);
  endtask

  // Idle until the model reaches phase index idx; an expired bound fails.
  task automatic run_to(input int idx, input int limit, input string tag);
    int n = 0;
    logic [NP-1:0] want;
    while (m_idx != idx && n < limit) begin
      tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= limit) begin
      want = '0;
      want[idx] = 1'b1;
      check(tag, phase, want);
    end
  endtask

  // Keep halt_req high until the model parks; an expired bound fails.
  task automatic halt_now(input string tag);
    int n = 0;
    while (m_mode != M_HALT && n < 12) begin
      tick('0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check(tag, halted, 1);
  endtask

  initial begin
    logic [31:0] base;
    int n;
    rst_n = 1'b0;
    busy = '0; halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0; clr_timeout = 1'b0;

    // Reset, then free run: 1,2,4,8,16 repeating; step/run ignored in RUN.
    do_reset();
    check("two_start_halted", s_halted, 1);
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 7) tick('0, 1'b0, 1'b1, 1'b1, 1'b0);
      else        tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("instret_after_20", instret, 4);

    // Memory-access phase busy for three cycles: no watchdog trip.
    run_to(3, 10, "reach_mem");
    base = m_ret;
    repeat (3) tick(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mem_hold_phase", phase, 5'b10000);
    check("mem_no_timeout", timeout, 0);
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mem_retire_once", instret, base + 1);

    // Execute phase stuck busy: held WAIT_MAX+1 cycles then forced on.
    run_to(2, 10, "reach_exec");
    repeat (WM + 1) tick(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd_phase", phase, 5'b01000);
    check("wd_timeout", timeout, 1);
    tick(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wd_cleared", timeout, 0);

    // Halt requested in decode: instruction completes, then parks.
    run_to(1, 10, "reach_decode");
    halt_now("halt_reached");
    tick('0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("run_blocked", halted, 1);
    tick('0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("resume_phase", phase, 1);

    // Single step from halted, then step+run together resumes running.
    halt_now("halt_again");
    base = m_ret;
    tick('0, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (m_mode != M_HALT && n < 12) begin
      tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("step_halted", halted, 1);
    check("step_instret", instret, base + 1);
    tick('0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (7) tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("run_wins", halted, 0);

    // Reset mid-phase with counters non-zero.
    do_reset();
    repeat (WM + 2) tick(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(m_ret == 7 && m_idx == 3) && n < 60) begin
      tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("pre_rst_instret", instret, 7);
    repeat (2) tick(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_phase", phase, 5'b01000);
    check("pre_rst_timeout", timeout, 1);
    do_reset();
    repeat (6) tick('0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two-phase, start-halted instance.
    #1;
    check("two_halted", s_halted, 1);
    check("two_phase_zero", s_phase, 0);
    s_run = 1'b1;
    @(negedge clk);
    s_run = 1'b0;
    #1;
    check("two_run_phase", s_phase, 2'b01);
    check("two_run_halted", s_halted, 0);
    @(negedge clk);
    #1;
    check("two_phase_wb", s_phase, 2'b10);
    check("two_retire", s_retire, 1);
    @(negedge clk);
    #1;
    check("two_wrap_phase", s_phase, 2'b01);
    check("two_instret1", s_instret, 1);
    s_busy = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("two_hold_phase", s_phase, 2'b01);
      check("two_hold_stall", s_stall, 2'b01);
      check("two_no_timeout", s_timeout, 0);
    end
    s_busy = 2'b00;
    repeat (508) @(negedge clk);
    #1;
    check("two_instret_ff", s_instret, 8'hFF);
    repeat (2) @(negedge clk);
    #1;
    check("two_instret_wrap", s_instret, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor to the core's fixed five-phase statemachine. It generates a one-hot phase sequence (fetch/decode/execute/memoryaccess/writeback by default) for the multi-cycle core. It adds per-phase wait-state extension, a wait timeout watchdog, halt/resume/single-step control at instruction boundaries, and a retired-instruction counter. It sits in the core top level and drives every stage's phase/stall inputs.

Parameters:
NPHASE, 5, number of phases per instruction (≥2); bit 0 = first phase (fetch), bit NPHASE-1 = last (writeback)
WAIT_MAX, 15, max consecutive busy cycles tolerated in one phase; 0 disables timeout
CNTW, 4, width of wait counter (must hold WAIT_MAX)
XLEN, 32, width of retired-instruction counter
START_HALTED, 0, 1 = come out of reset halted

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
phase_busy  in  NPHASE  stage i requests the current phase be extended (level)
halt_req  in  1  request halt at next instruction boundary (level)
run_req  in  1  resume free-running from halted (pulse or level)
step_req  in  1  execute exactly one instruction from halted (pulse)
clr_timeout  in  1  clears sticky timeout flag
phase  out  NPHASE  one-hot active phase; all-zero when halted
stall  out  NPHASE  stall[i] = phase[i] & phase_busy[i] & ~force_adv (combinational)
retire  out  1  1-cycle pulse (combinational) when last phase completes
halted  out  1  sequencer is parked at an instruction boundary
timeout  out  1  sticky: a phase was force-advanced by the watchdog
instret  out  XLEN  retired-instruction count, wraps modulo 2^XLEN

Behaviour:
- Reset (async, rst_n=0): phase=0, wait_cnt=0, instret=0, timeout=0, halted=START_HALTED. First edge after release with START_HALTED=0: phase <= 1 (bit 0).
- States: RUN, STEP, HALTED (plus phase pointer held as one-hot register).
- Advance: in RUN/STEP with phase[i]=1, adv = ~phase_busy[i] | force_adv. On adv, next phase = bit (i+1) mod NPHASE; wait_cnt <= 0. When not advancing, phase holds and wait_cnt++.
- Watchdog: force_adv = (WAIT_MAX≠0) & phase_busy[i] & (wait_cnt == WAIT_MAX). With WAIT_MAX=W, a phase busy forever stays active W+1 cycles, then advances; timeout <= 1 in the same edge. clr_timeout clears; simultaneous set and clear: set wins.
- Boundary: retire = phase[NPHASE-1] & adv. On retire, instret++ (wraps to 0 from all-ones).
- Halt: on retire in RUN with halt_req=1 -> HALTED: phase <= 0, halted <= 1. halt_req mid-instruction has no effect until retire. halt_req while HALTED is ignored.
- STEP: on retire in STEP -> HALTED (phase 0, halted 1) regardless of halt_req.
- HALTED: run_req=1 & halt_req=0 -> RUN, phase <= bit0, halted <= 0. Otherwise step_req=1 -> STEP, phase <= bit0, halted <= 0. run_req and step_req together: run wins if allowed, otherwise step. phase_busy is ignored while halted; stall=0 and retire=0.
- step_req/run_req outside HALTED are ignored.
- NPHASE=2 must wrap correctly. No X on outputs after reset. Invariant: phase is always one-hot or zero.

Test Plan:
- Free run, NPHASE=5, phase_busy=0: after reset release phase = 1,2,4,8,16,1…; retire every 5th cycle; instret=4 after 20 cycles.
- phase_busy[3]=1 for 3 cycles in memoryaccess -> phase=8 held 4 cycles, stall[3]=1 for 3 of them, no timeout; instret advances once.
- WAIT_MAX=4, phase_busy[2] stuck at 1 -> phase=4 held exactly 5 cycles, then phase=8 and timeout=1 stays set; clr_timeout -> 0.
- halt_req raised during phase=2 -> instruction completes, retire pulses, then phase=0 and halted=1; a run_req with halt_req still high is ignored; dropping halt_req then run_req -> phase=1 next cycle.
- From halted, step_req pulse -> one 5-phase pass, instret +1, back to halted with phase=0; step_req+run_req same cycle (halt_req=0) -> RUN.
- Assert rst_n=0 mid-phase (phase=8, wait_cnt=2, instret=7) -> immediately phase=0, instret=0, timeout=0; START_HALTED=1 build stays halted after release until run_req.
